// File: rtl/qk_inst_seq.sv
// Autonomous instruction sequencer for one Q/K attention pass: Q/K fill, K load, execute, ofifo drain.
// Optional QK_SEQ_PMEM_RDBK_EN adds a pmem read-back phase after the drain.
module qk_inst_seq #(
    parameter int NUM_Q    = 8,
    parameter int NUM_K    = 8,
    parameter int ADDR_W   = 4,
    parameter int LOAD_GAP = 10,
    parameter int EXEC_GAP = 10,
    localparam int INST_W  = 9 + 2*ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              vec_vld,
    output logic              vec_rdy,
    output logic              vec_sel,
    output logic [ADDR_W-1:0] vec_idx,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);
    localparam int GAP_MAX = (LOAD_GAP > EXEC_GAP + 1) ? LOAD_GAP : EXEC_GAP + 1;
    localparam int CNT_W   = ($clog2(GAP_MAX + 1) > ADDR_W + 1) ? $clog2(GAP_MAX + 1) : ADDR_W + 1;

    localparam int B_PWR   = 0;
    localparam int B_PRD   = 1;
    localparam int B_KWR   = 2;
    localparam int B_KRD   = 3;
    localparam int B_QWR   = 4;
    localparam int B_QRD   = 5;
    localparam int B_LOAD  = 6;
    localparam int B_EXEC  = 7;
    localparam int PA_LSB  = 8;
    localparam int QA_LSB  = 8 + ADDR_W;
    localparam int B_OFIFO = INST_W - 1;

    localparam logic [CNT_W-1:0] LAST_Q  = CNT_W'(NUM_Q - 1);
    localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(NUM_K - 1);
    localparam logic [CNT_W-1:0] LAST_KL = CNT_W'(NUM_K);
    localparam logic [CNT_W-1:0] LAST_LG = CNT_W'(LOAD_GAP - 1);
    localparam logic [CNT_W-1:0] LAST_EG = CNT_W'(EXEC_GAP);
    localparam logic [CNT_W-1:0] LAST_GA = CNT_W'(2);

    if (ADDR_W < 1 || NUM_Q < 1 || NUM_Q > (1 << ADDR_W) || NUM_K < 1 ||
        NUM_K > (1 << ADDR_W) - 1 || LOAD_GAP < 1 || EXEC_GAP < 0) begin : g_bad_param
        $error("qk_inst_seq: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_QWR    = 4'd1,
        S_KWR    = 4'd2,
        S_GAPA   = 4'd3,
        S_KLOAD  = 4'd4,
        S_KDRAIN = 4'd5,
        S_LGAP   = 4'd6,
        S_EXEC   = 4'd7,
        S_EGAP   = 4'd8,
        S_DRAIN  = 4'd9,
`ifdef QK_SEQ_PMEM_RDBK_EN
        S_RDBK   = 4'd10,
`endif
        S_DONE   = 4'd11
    } state_t;

    state_t             st_q, st_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  hold_q, hold_d;
    logic [INST_W-1:0]  inst_q, inst_d, wr_word;
    logic               vec_rdy_q, vec_rdy_d;
    logic               vec_sel_q, vec_sel_d;
    logic [ADDR_W-1:0]  vec_idx_q, vec_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;

    // Registered instruction for a given state/count; write strobes are overlaid separately.
    function automatic logic [INST_W-1:0] enc(input state_t st, input logic [CNT_W-1:0] c,
                                              input logic [ADDR_W-1:0] hold);
        logic [INST_W-1:0] w;
        w = '0;
        case (st)
            S_QWR, S_KWR: w[QA_LSB +: ADDR_W] = hold;
            S_KLOAD: begin
                w[B_LOAD] = 1'b1;
                w[B_KRD]  = (c != '0);
                if (c > CNT_W'(1)) w[QA_LSB +: ADDR_W] = ADDR_W'(c - CNT_W'(1));
            end
            S_KDRAIN: w[B_LOAD] = 1'b1;
            S_EXEC: begin
                w[B_EXEC] = 1'b1;
                w[B_QRD]  = 1'b1;
                w[QA_LSB +: ADDR_W] = ADDR_W'(c);
            end
            S_DRAIN: begin
                w[B_OFIFO] = 1'b1;
                w[B_PWR]   = 1'b1;
                w[PA_LSB +: ADDR_W] = ADDR_W'(c);
            end
`ifdef QK_SEQ_PMEM_RDBK_EN
            S_RDBK: begin
                w[B_PRD] = 1'b1;
                w[PA_LSB +: ADDR_W] = ADDR_W'(c);
            end
`endif
            default: ;
        endcase
        return w;
    endfunction

    assign accept = vec_rdy_q & vec_vld;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        case (st_q)
            S_IDLE: if (start) begin
                st_d   = S_QWR;
                cnt_d  = '0;
                hold_d = '0;
            end
            S_QWR: if (accept) begin
                hold_d = vec_idx_q;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_Q) begin
                    st_d   = S_KWR;
                    cnt_d  = '0;
                    hold_d = '0;
                end
            end
            S_KWR: if (accept) begin
                hold_d = vec_idx_q;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_K) begin
                    st_d  = S_GAPA;
                    cnt_d = '0;
                end
            end
            S_GAPA:   begin cnt_d = cnt_q + CNT_W'(1); if (cnt_q == LAST_GA) begin st_d = S_KLOAD; cnt_d = '0; end end
            S_KLOAD:  begin cnt_d = cnt_q + CNT_W'(1); if (cnt_q == LAST_KL) begin st_d = S_KDRAIN; cnt_d = '0; end end
            S_KDRAIN: begin st_d = S_LGAP; cnt_d = '0; end
            S_LGAP:   begin cnt_d = cnt_q + CNT_W'(1); if (cnt_q == LAST_LG) begin st_d = S_EXEC; cnt_d = '0; end end
            S_EXEC:   begin cnt_d = cnt_q + CNT_W'(1); if (cnt_q == LAST_Q) begin st_d = S_EGAP; cnt_d = '0; end end
            S_EGAP:   begin cnt_d = cnt_q + CNT_W'(1); if (cnt_q == LAST_EG) begin st_d = S_DRAIN; cnt_d = '0; end end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_Q) begin
`ifdef QK_SEQ_PMEM_RDBK_EN
                    st_d = S_RDBK;
`else
                    st_d = S_DONE;
`endif
                    cnt_d = '0;
                end
            end
`ifdef QK_SEQ_PMEM_RDBK_EN
            S_RDBK:   begin cnt_d = cnt_q + CNT_W'(1); if (cnt_q == LAST_Q) begin st_d = S_DONE; cnt_d = '0; end end
`endif
            S_DONE:   begin st_d = S_IDLE; cnt_d = '0; end
            default:  begin st_d = S_IDLE; cnt_d = '0; end
        endcase

        inst_d    = enc(st_d, cnt_d, hold_d);
        vec_rdy_d = (st_d == S_QWR) || (st_d == S_KWR);
        vec_sel_d = (st_d == S_KWR);
        vec_idx_d = vec_rdy_d ? ADDR_W'(cnt_d) : '0;
        busy_d    = (st_d != S_IDLE);
        done_d    = (st_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= S_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            inst_q    <= '0;
            vec_rdy_q <= 1'b0;
            vec_sel_q <= 1'b0;
            vec_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            inst_q    <= inst_d;
            vec_rdy_q <= vec_rdy_d;
            vec_sel_q <= vec_sel_d;
            vec_idx_q <= vec_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The write strobe must coincide with the host's vec_vld, so it gates the registered word.
    always_comb begin
        wr_word = '0;
        wr_word[QA_LSB +: ADDR_W] = vec_idx_q;
        wr_word[B_QWR] = ~vec_sel_q;
        wr_word[B_KWR] = vec_sel_q;
        inst = accept ? wr_word : inst_q;
    end

    assign vec_rdy = vec_rdy_q;
    assign vec_sel = vec_sel_q;
    assign vec_idx = vec_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_qk_inst_seq.sv
// Randomized self-checking bench for qk_inst_seq: default instance plus a NUM_Q=16/NUM_K=15 instance.
module tb_qk_inst_seq;
    localparam int LG = 10;
    localparam int EG = 10;
    localparam logic [7:0] C_EXEC = 8'h80, C_LOAD = 8'h40, C_QRD = 8'h20, C_QWR = 8'h10;
    localparam logic [7:0] C_KRD  = 8'h08, C_KWR  = 8'h04, C_PRD = 8'h02, C_PWR = 8'h01;

    logic clk = 1'b0;
    logic reset, start_a, start_b, vec_vld, use_b;
    logic rdy_a, sel_a, busy_a, done_a, rdy_b, sel_b, busy_b, done_b;
    logic [3:0]  idx_a, idx_b;
    logic [16:0] inst_a, inst_b;
    logic [16:0] o_inst;
    logic [3:0]  o_idx;
    logic        o_rdy, o_sel, o_busy, o_done;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qk_inst_seq dut_a (
        .clk(clk), .reset(reset), .start(start_a), .vec_vld(vec_vld),
        .vec_rdy(rdy_a), .vec_sel(sel_a), .vec_idx(idx_a), .inst(inst_a),
        .busy(busy_a), .done(done_a)
    );

    qk_inst_seq #(.NUM_Q(16), .NUM_K(15)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .vec_vld(vec_vld),
        .vec_rdy(rdy_b), .vec_sel(sel_b), .vec_idx(idx_b), .inst(inst_b),
        .busy(busy_b), .done(done_b)
    );

    always_comb begin
        o_inst = use_b ? inst_b : inst_a;
        o_idx  = use_b ? idx_b  : idx_a;
        o_rdy  = use_b ? rdy_b  : rdy_a;
        o_sel  = use_b ? sel_b  : sel_a;
        o_busy = use_b ? busy_b : busy_a;
        o_done = use_b ? done_b : done_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(input bit ofifo, input int qa, input int pa, input logic [7:0] ctl);
        logic [3:0] q, p;
        q = 4'(qa);
        p = 4'(pa);
        return {ofifo, q, p, ctl};
    endfunction

    task automatic drive_start(input logic b, input logic s);
        if (b) start_b = s;
        else   start_a = s;
    endtask

    // mode 0: vec_vld always 1; mode 1: random vld/start; mode 2: 4-cycle stall after 3rd Q accept.
    task automatic run_pass(input logic b, input int nq, input int nk, input int mode, input int abort_idx);
        logic [16:0] tail[$];
        int cnt, last, n, stall;
        logic vld;
        use_b = b;
        tail.delete();
        repeat (3) tail.push_back(17'd0);
        for (int c = 0; c <= nk; c++)
            tail.push_back(mk(0, (c >= 2) ? c - 1 : 0, 0, C_LOAD | ((c >= 1) ? C_KRD : 8'h00)));
        tail.push_back(mk(0, 0, 0, C_LOAD));
        repeat (LG) tail.push_back(17'd0);
        for (int c = 0; c < nq; c++) tail.push_back(mk(0, c, 0, C_EXEC | C_QRD));
        repeat (1 + EG) tail.push_back(17'd0);
        for (int c = 0; c < nq; c++) tail.push_back(mk(1, 0, c, C_PWR));
`ifdef QK_SEQ_PMEM_RDBK_EN
        for (int c = 0; c < nq; c++) tail.push_back(mk(0, 0, c, C_PRD));
`endif
        tail.push_back(17'd0);

        drive_start(b, 1'b1);
        #1 check("idle_busy", o_busy, 0);
        @(negedge clk);
        drive_start(b, 1'b0);
        stall = 0;
        for (int ph = 0; ph < 2; ph++) begin
            cnt  = 0;
            last = 0;
            n    = ph ? nk : nq;
            while (cnt < n) begin
                if (mode == 1) begin
                    vld = ($urandom_range(0, 3) != 0);
                    drive_start(b, 1'($urandom_range(0, 1)));
                end else if (mode == 2 && ph == 0 && cnt == 3 && stall < 4) begin
                    vld = 1'b0;
                    stall++;
                end else begin
                    vld = 1'b1;
                end
                vec_vld = vld;
                #1;
                check("wr_rdy", o_rdy, 1);
                check("wr_sel", o_sel, 32'(ph));
                check("wr_idx", o_idx, 32'(cnt));
                check("wr_busy", o_busy, 1);
                check("wr_inst", o_inst, vld ? mk(0, cnt, 0, ph ? C_KWR : C_QWR) : mk(0, last, 0, 8'h00));
                if (vld) begin
                    last = cnt;
                    cnt++;
                end
                @(negedge clk);
            end
        end
        foreach (tail[i]) begin
            if (mode == 1) begin
                vec_vld = 1'($urandom_range(0, 1));
                drive_start(b, 1'($urandom_range(0, 1)));
            end
            #1;
            check("seq_inst", o_inst, tail[i]);
            check("seq_rdy", o_rdy, 0);
            check("seq_busy", o_busy, 1);
            check("seq_done", o_done, 32'(i == tail.size() - 1));
            if (i == abort_idx) begin
                #2 reset = 1'b0;
                #1;
                check("abort_inst", o_inst, 0);
                check("abort_busy", o_busy, 0);
                check("abort_done", o_done, 0);
                drive_start(b, 1'b0);
                vec_vld = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    check("abort_hold_done", o_done, 0);
                    check("abort_hold_inst", o_inst, 0);
                end
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            @(negedge clk);
        end
        drive_start(b, 1'b0);
        vec_vld = 1'b0;
        #1;
        check("post_busy", o_busy, 0);
        check("post_done", o_done, 0);
        check("post_inst", o_inst, 0);
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        vec_vld = 1'b0;
        use_b   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_inst_a", inst_a, 0);
            check("rst_busy_a", busy_a, 0);
            check("rst_rdy_a", rdy_a, 0);
            check("rst_inst_b", inst_b, 0);
            check("rst_done_b", done_b, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            #1;
            check("idle_inst", inst_a, 0);
            check("idle_busy", busy_a, 0);
            check("idle_done", done_a, 0);
            @(negedge clk);
        end
        run_pass(1'b0, 8, 8, 0, -1);
        run_pass(1'b0, 8, 8, 2, -1);
        run_pass(1'b0, 8, 8, 1, -1);
        run_pass(1'b0, 8, 8, 0, 3 + 9 + 1 + LG + 5);
        run_pass(1'b0, 8, 8, 0, -1);
        run_pass(1'b1, 16, 15, 0, -1);
        run_pass(1'b1, 16, 15, 1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/qk_inst_seq.md
Name: qk_inst_seq

Overview:
- Parametrised instruction sequencer that drives the core's 17-bit-class `inst` word autonomously.
- Replaces hand-stepped instruction streams.
- Runs one full attention pass: Q-mem fill, K-mem fill, K load into the array, execute, then the ofifo→pmem drain.
- Sits between the host/data-feed logic and `core.inst`. The host supplies Q/K vectors on `mem_in` under a valid/ready handshake.

Parameters:
- NUM_Q, 8, number of Q vectors per pass (1..2^ADDR_W).
- NUM_K, 8, number of K vectors / array columns (1..2^ADDR_W-1).
- ADDR_W, 4, width of the qkmem_add and pmem_add fields.
- LOAD_GAP, 10, idle cycles after K load before execute (≥1).
- EXEC_GAP, 10, idle cycles after execute before the ofifo drain (≥0).
- INST_W, 9+2*ADDR_W, derived width of inst; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse to begin a pass; sampled in IDLE only.
- vec_vld  in  1  host has a vector on mem_in this cycle.
- vec_rdy  out  1  sequencer accepts a vector this cycle.
- vec_sel  out  1  0 = Q vector requested, 1 = K vector requested.
- vec_idx  out  ADDR_W  index of the requested vector.
- inst  out  INST_W  core instruction word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- inst field map, MSB→LSB:
  - ofifo_rd
  - qkmem_add[ADDR_W]
  - pmem_add[ADDR_W]
  - execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr.
- All outputs are registered. While reset=0, all outputs = 0 and state = IDLE, immediately (async).
- A reset asserted mid-pass aborts the pass: inst goes to 0 at once, no done pulse, and IDLE is entered on release.
- FSM states, each with cycles spent and required outputs. Any field not listed is 0.
  - IDLE: inst=0. start=1 → QWR next cycle. start while busy is ignored.
  - QWR:
    - vec_rdy=1, vec_sel=0, vec_idx = accepted count.
    - qmem_wr = vec_vld, qkmem_add = vec_idx.
    - A write is accepted only when vec_vld=1. vec_vld=0 stalls with qmem_wr=0 and the address held.
    - After the NUM_Q-th accept → KWR, with the count cleared.
  - KWR: identical to QWR, with kmem_wr and vec_sel=1. After NUM_K accepts → GAPA.
  - GAPA: 3 cycles, inst=0, vec_rdy=0.
  - KLOAD: NUM_K+1 cycles, load=1 throughout.
    - Cycle 0: kmem_rd=0, add=0.
    - Cycle 1: kmem_rd=1, add=0.
    - Cycle c≥2: kmem_rd=1, qkmem_add=c-1.
  - KDRAIN: 1 cycle, load=1, kmem_rd=0, add=0.
  - LGAP: LOAD_GAP cycles, inst=0.
  - EXEC: NUM_Q cycles, execute=1, qmem_rd=1, qkmem_add = cycle index 0..NUM_Q-1.
  - EGAP: 1+EXEC_GAP cycles, inst=0.
  - DRAIN: NUM_Q cycles, ofifo_rd=1, pmem_wr=1, pmem_add = cycle index.
  - DONE: 1 cycle, inst=0, done=1, then IDLE. start seen in the DONE cycle is ignored.
- Counters are ADDR_W+1 bits wide, so a count equal to 2^ADDR_W terminates without wrap. Address fields never wrap within a phase.
- Unstalled pass length: NUM_Q + NUM_K + 3 + NUM_K+1 + 1 + LOAD_GAP + NUM_Q + 1+EXEC_GAP + NUM_Q + 1 cycles. This is 67 with the defaults.
- Out-of-range parameters are an elaboration error, raised by a generate-time check.

Optional Feature:
- Macro: QK_SEQ_PMEM_RDBK_EN.
- Defined:
  - After DRAIN, enter RDBK for NUM_Q cycles with pmem_rd=1 and pmem_add = cycle index 0..NUM_Q-1, then DONE.
  - Pass length grows by NUM_Q (75 with defaults).
- Undefined: RDBK does not exist, DRAIN goes directly to DONE, and the pmem_rd bit is tied to 0.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no start → inst=0, busy=0, done=0 for 20 cycles.
- Nominal pass (defaults, vec_vld=1 always): start at cycle 0 →
  - qmem_wr high in cycles 1–8 with qkmem_add 0..7.
  - kmem_wr high in cycles 9–16.
  - load high in cycles 20–29.
  - execute high in cycles 40–47.
  - ofifo_rd/pmem_wr high in cycles 59–66 with pmem_add 0..7.
  - done=1 in cycle 67.
- Handshake stall: drop vec_vld for 4 cycles after the 3rd Q accept → qmem_wr=0 and qkmem_add=2 held during the stall; all 8 Q addresses are written exactly once; done is delayed by exactly 4 cycles.
- Mid-pass reset: assert reset=0 during EXEC at qkmem_add=5 → inst=0 in the same cycle without waiting for a clock edge; no done; after release a new start runs a full 67-cycle pass.
- Parameter sweep: NUM_Q=16, NUM_K=15, ADDR_W=4 → EXEC addresses 0..15 with no wrap; KLOAD lasts 16 cycles with final qkmem_add=14; pass length 16+15+3+16+1+10+16+11+16+1 = 105.
- With QK_SEQ_PMEM_RDBK_EN defined: defaults → pmem_rd high in cycles 67–74 with pmem_add 0..7; done in cycle 75. Without the macro, pmem_rd is never 1.
